// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART serialiser on the FTDI-facing uart_tx pin.
// Latency: a byte accepted into an empty FIFO with an idle line at edge N drives the start bit from edge N+1.
// Backpressure: tx_ready is low while the FIFO holds 2**FIFO_AW bytes; a full FIFO never passes a byte through.
// Build option: define UART_TX_PARITY_EN for 8E1 frames (11 bit periods); default is 8N1 (10 bit periods).

// sync_fifo: generic single-clock FIFO with an occupancy count and a show-ahead head.
// Latency: a pushed entry is visible at rd_dat and counted one edge after the push.
// Backpressure: wr_rdy is low when full; writes are refused then even if a pop happens on the same edge.
module sync_fifo #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_vld,
    input  logic [DW-1:0] wr_dat,
    output logic          wr_rdy,
    input  logic          rd_en,
    output logic [DW-1:0] rd_dat,
    output logic [AW:0]   count
);
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_fire;
    logic          rd_fire;

    // Full-ness comes only from the registered count, so a same-edge pop cannot open a slot.
    assign wr_rdy  = (count < DEPTH);
    assign wr_fire = wr_vld && wr_rdy;
    assign rd_fire = rd_en && (count != '0);
    assign rd_dat  = mem[rd_ptr];

    // Storage array: only accepted pushes write; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally modulo depth; count holds on simultaneous push and pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// uart_tx_fifo: queues bytes and serialises them LSB first at CLKS_PER_BIT clocks per bit.
// Latency: start bit appears on uart_tx one edge after the byte reaches an empty FIFO with the FSM idle.
// Backpressure: tx_ready = fifo_count < 2**FIFO_AW; back-to-back frames leave no idle gap.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 1250,
    parameter int FIFO_AW      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             uart_tx,
    output logic             busy,
    output logic [FIFO_AW:0] fifo_count
);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] baud_cnt;
    logic [CW-1:0] baud_nxt;
    logic [2:0]    bit_idx;
    logic [2:0]    idx_nxt;
    logic [7:0]    shift;
    logic [7:0]    shift_nxt;
    logic          tx_q;
    logic          tx_nxt;
    logic          pop;
    logic          bit_end;
    logic [7:0]    head;
`ifdef UART_TX_PARITY_EN
    logic          par_q;
    logic          par_nxt;
`endif

    sync_fifo #(
        .DW (8),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (tx_valid),
        .wr_dat (tx_data),
        .wr_rdy (tx_ready),
        .rd_en  (pop),
        .rd_dat (head),
        .count  (fifo_count)
    );

    assign bit_end = (baud_cnt == BAUD_LAST);
    assign uart_tx = tx_q;
    assign busy    = (state != IDLE);

    // Next-state logic; uart_tx is computed one edge ahead so the pin comes straight from a flop.
    always_comb begin
        state_nxt = state;
        baud_nxt  = bit_end ? '0 : baud_cnt + 1'b1;
        idx_nxt   = bit_idx;
        shift_nxt = shift;
        tx_nxt    = tx_q;
        pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_nxt   = par_q;
`endif
        case (state)
            IDLE: begin
                baud_nxt = '0;
                tx_nxt   = 1'b1;
                if (fifo_count != '0) begin
                    pop       = 1'b1;
                    shift_nxt = head;
`ifdef UART_TX_PARITY_EN
                    par_nxt   = ^head;
`endif
                    state_nxt = START;
                    tx_nxt    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt = DATA;
                    idx_nxt   = 3'd0;
                    tx_nxt    = shift[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_nxt = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = PARITY;
                        tx_nxt    = par_q;
`else
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
`endif
                    end else begin
                        idx_nxt = bit_idx + 3'd1;
                        tx_nxt  = shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP;
                    tx_nxt    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (fifo_count != '0) begin
                        // Chain straight into the next start bit: no idle cycle between frames.
                        pop       = 1'b1;
                        shift_nxt = head;
`ifdef UART_TX_PARITY_EN
                        par_nxt   = ^head;
`endif
                        state_nxt = START;
                        tx_nxt    = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                        tx_nxt    = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                baud_nxt  = '0;
                tx_nxt    = 1'b1;
            end
        endcase
    end

    // State register: reset aborts any frame in flight and returns the line to idle high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= idx_nxt;
            shift    <= shift_nxt;
            tx_q     <= tx_nxt;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo at full baud (1250) and a fast baud (4).
// Latency: expected line slots and edge numbers are hand-derived from the push edge.
// Backpressure: the fast instance is driven into a full FIFO to observe tx_ready.
module tb_uart_tx_fifo;
    localparam int SC = 1250;
    localparam int FC = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;

    logic       s_rst, s_valid, s_ready, s_uart, s_busy;
    logic [7:0] s_data;
    logic [2:0] s_count;
    logic       f_rst, f_valid, f_ready, f_uart, f_busy;
    logic [7:0] f_data;
    logic [2:0] f_count;

    logic [7:0] mon_q[$];
    bit         mon_ok[$];
    int         mon_st[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_fifo #(.CLKS_PER_BIT(SC), .FIFO_AW(2)) u_slow (
        .clk(clk), .rst(s_rst), .tx_data(s_data), .tx_valid(s_valid), .tx_ready(s_ready),
        .uart_tx(s_uart), .busy(s_busy), .fifo_count(s_count)
    );

    uart_tx_fifo #(.CLKS_PER_BIT(FC), .FIFO_AW(2)) u_fast (
        .clk(clk), .rst(f_rst), .tx_data(f_data), .tx_valid(f_valid), .tx_ready(f_ready),
        .uart_tx(f_uart), .busy(f_busy), .fifo_count(f_count)
    );

    // Wait until the negedge following posedge number t (returns at once if already past).
    task automatic goto(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Expected line level per bit slot: slot 0 start, 1..8 data LSB first, then parity/stop.
    function automatic logic [10:0] exp_frame(input logic [7:0] d);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef UART_TX_PARITY_EN
        f[9]   = ^d;
        f[10]  = 1'b1;
`else
        f[9]   = 1'b1;
`endif
        return f;
    endfunction

    // Receiver model on the fast instance: samples each slot mid-bit and logs byte, framing and start edge.
    always begin : mon
        int         st;
        logic [7:0] d;
        bit         ok;
        @(negedge clk);
        if (f_rst === 1'b0 && f_uart === 1'b0) begin
            st = cyc;
            ok = 1'b1;
            goto(st + FC / 2);
            if (f_uart !== 1'b0) ok = 1'b0;
            for (int k = 0; k < 8; k++) begin
                goto(st + (k + 1) * FC + FC / 2);
                d[k] = f_uart;
            end
`ifdef UART_TX_PARITY_EN
            goto(st + 9 * FC + FC / 2);
            if (f_uart !== ^d) ok = 1'b0;
`endif
            goto(st + (NB - 1) * FC + FC / 2);
            if (f_uart !== 1'b1) ok = 1'b0;
            mon_q.push_back(d);
            mon_ok.push_back(ok);
            mon_st.push_back(st);
        end
    end

    task automatic mon_clear();
        mon_q.delete();
        mon_ok.delete();
        mon_st.delete();
    endtask

    task automatic test_reset();
        goto(3);
        n_vec++; if (s_uart !== 1'b1)    begin n_err++; $display("FAIL reset_slow_uart: got %b want 1", s_uart); end
        n_vec++; if (s_busy !== 1'b0)    begin n_err++; $display("FAIL reset_slow_busy: got %b want 0", s_busy); end
        n_vec++; if (s_ready !== 1'b1)   begin n_err++; $display("FAIL reset_slow_ready: got %b want 1", s_ready); end
        n_vec++; if (s_count !== 3'd0)   begin n_err++; $display("FAIL reset_slow_count: got %0d want 0", s_count); end
        n_vec++; if (f_uart !== 1'b1)    begin n_err++; $display("FAIL reset_fast_uart: got %b want 1", f_uart); end
        n_vec++; if (f_busy !== 1'b0)    begin n_err++; $display("FAIL reset_fast_busy: got %b want 0", f_busy); end
        n_vec++; if (f_ready !== 1'b1)   begin n_err++; $display("FAIL reset_fast_ready: got %b want 1", f_ready); end
        n_vec++; if (f_count !== 3'd0)   begin n_err++; $display("FAIL reset_fast_count: got %0d want 0", f_count); end
        s_rst = 1'b0;
        f_rst = 1'b0;
        goto(cyc + 2);
    endtask

    task automatic test_single();
        int          n;
        logic [10:0] capt;
        capt    = '1;
        n       = cyc + 1;
        s_data  = 8'h0D;
        s_valid = 1'b1;
        goto(n);
        s_valid = 1'b0;
        n_vec++; if (s_count !== 3'd1) begin n_err++; $display("FAIL single_queued: count %0d want 1", s_count); end
        n_vec++; if (s_uart !== 1'b1)  begin n_err++; $display("FAIL single_early: uart %b want 1 at push edge", s_uart); end
        goto(n + 1);
        n_vec++; if (s_uart !== 1'b0 || s_busy !== 1'b1 || s_count !== 3'd0) begin
            n_err++; $display("FAIL single_start: uart %b busy %b count %0d want 0 1 0", s_uart, s_busy, s_count);
        end
        for (int k = 0; k < NB; k++) begin
            goto(n + 1 + k * SC + SC / 2);
            capt[k] = s_uart;
        end
        n_vec++; if (capt !== exp_frame(8'h0D)) begin
            n_err++; $display("FAIL single_frame: slots %b want %b", capt, exp_frame(8'h0D));
        end
        goto(n + NB * SC);
        n_vec++; if (s_busy !== 1'b1 || s_uart !== 1'b1) begin
            n_err++; $display("FAIL single_last_stop: busy %b uart %b want 1 1", s_busy, s_uart);
        end
        goto(n + 1 + NB * SC);
        n_vec++; if (s_busy !== 1'b0 || s_count !== 3'd0 || s_uart !== 1'b1) begin
            n_err++; $display("FAIL single_end: busy %b count %0d uart %b want 0 0 1", s_busy, s_count, s_uart);
        end
    endtask

    task automatic test_back_to_back();
        int          n, st2;
        logic [10:0] c1, c2;
        c1      = '1;
        c2      = '1;
        n       = cyc + 1;
        st2     = n + 1 + NB * SC;
        s_data  = 8'h0D;
        s_valid = 1'b1;
        goto(n);
        s_data  = 8'h0A;
        goto(n + 1);
        s_valid = 1'b0;
        n_vec++; if (s_count !== 3'd1 || s_uart !== 1'b0) begin
            n_err++; $display("FAIL b2b_first_start: count %0d uart %b want 1 0", s_count, s_uart);
        end
        for (int k = 0; k < NB; k++) begin
            goto(n + 1 + k * SC + SC / 2);
            c1[k] = s_uart;
        end
        n_vec++; if (c1 !== exp_frame(8'h0D)) begin
            n_err++; $display("FAIL b2b_frame1: slots %b want %b", c1, exp_frame(8'h0D));
        end
        goto(st2 - 1);
        n_vec++; if (s_uart !== 1'b1 || s_busy !== 1'b1) begin
            n_err++; $display("FAIL b2b_stop_tail: uart %b busy %b want 1 1", s_uart, s_busy);
        end
        goto(st2);
        n_vec++; if (s_uart !== 1'b0 || s_busy !== 1'b1 || s_count !== 3'd0) begin
            n_err++; $display("FAIL b2b_second_start: uart %b busy %b count %0d want 0 1 0", s_uart, s_busy, s_count);
        end
        for (int k = 0; k < NB; k++) begin
            goto(st2 + k * SC + SC / 2);
            c2[k] = s_uart;
        end
        n_vec++; if (c2 !== exp_frame(8'h0A)) begin
            n_err++; $display("FAIL b2b_frame2: slots %b want %b", c2, exp_frame(8'h0A));
        end
        goto(st2 + NB * SC);
        n_vec++; if (s_busy !== 1'b0) begin n_err++; $display("FAIL b2b_end_busy: got %b want 0", s_busy); end
    endtask

    task automatic test_full();
        int   e1, b;
        int   acc [1:6];
        logic was_rdy;
        mon_clear();
        acc     = '{default: 0};
        e1      = cyc + 1;
        b       = 1;
        f_data  = 8'h01;
        f_valid = 1'b1;
        while (b <= 6 && cyc < e1 + 200) begin
            was_rdy = f_ready;
            if (cyc == e1 + 4) begin
                n_vec++; if (f_count !== 3'd4 || f_ready !== 1'b0) begin
                    n_err++; $display("FAIL full_state: count %0d ready %b want 4 0", f_count, f_ready);
                end
            end
            @(negedge clk);
            if (was_rdy) begin
                acc[b] = cyc;
                b++;
                f_data = 8'(b);
            end
        end
        f_valid = 1'b0;
        n_vec++; if (b != 7) begin n_err++; $display("FAIL full_timeout: accepted %0d bytes want 6", b - 1); end
        n_vec++; if (acc[5] != e1 + 4) begin n_err++; $display("FAIL full_fill_edge: 0x05 at %0d want %0d", acc[5], e1 + 4); end
        n_vec++; if (acc[6] != e1 + 2 + NB * FC) begin
            n_err++; $display("FAIL full_reopen_edge: 0x06 at %0d want %0d", acc[6], e1 + 2 + NB * FC);
        end
        goto(e1 + 1 + 6 * NB * FC + 4);
        n_vec++; if (mon_q.size() != 6) begin n_err++; $display("FAIL full_nbytes: got %0d want 6", mon_q.size()); end
        for (int i = 0; i < 6 && i < mon_q.size(); i++) begin
            n_vec++; if (mon_q[i] !== 8'(i + 1) || !mon_ok[i] || mon_st[i] != e1 + 1 + i * NB * FC) begin
                n_err++; $display("FAIL full_byte%0d: got %h ok %0d start %0d want %h 1 %0d",
                                  i, mon_q[i], mon_ok[i], mon_st[i], 8'(i + 1), e1 + 1 + i * NB * FC);
            end
        end
        n_vec++; if (f_busy !== 1'b0 || f_count !== 3'd0) begin
            n_err++; $display("FAIL full_drain: busy %b count %0d want 0 0", f_busy, f_count);
        end
    endtask

    task automatic test_push_pop();
        int         e1, p;
        logic [7:0] exp_b [4];
        exp_b = '{8'hA5, 8'h3C, 8'h81, 8'h7E};
        mon_clear();
        e1      = cyc + 1;
        p       = e1 + 1 + NB * FC;
        f_data  = 8'hA5;
        f_valid = 1'b1;
        goto(e1);
        f_data  = 8'h3C;
        goto(e1 + 1);
        f_data  = 8'h81;
        goto(e1 + 2);
        f_valid = 1'b0;
        goto(p - 1);
        n_vec++; if (f_count !== 3'd2) begin n_err++; $display("FAIL pushpop_pre: count %0d want 2", f_count); end
        f_data  = 8'h7E;
        f_valid = 1'b1;
        goto(p);
        f_valid = 1'b0;
        n_vec++; if (f_count !== 3'd2 || f_uart !== 1'b0) begin
            n_err++; $display("FAIL pushpop_edge: count %0d uart %b want 2 0", f_count, f_uart);
        end
        goto(e1 + 1 + 4 * NB * FC + 4);
        n_vec++; if (mon_q.size() != 4) begin n_err++; $display("FAIL pushpop_nbytes: got %0d want 4", mon_q.size()); end
        for (int i = 0; i < 4 && i < mon_q.size(); i++) begin
            n_vec++; if (mon_q[i] !== exp_b[i] || !mon_ok[i]) begin
                n_err++; $display("FAIL pushpop_byte%0d: got %h ok %0d want %h 1", i, mon_q[i], mon_ok[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int e1, r, bad, e;
        mon_clear();
        e1      = cyc + 1;
        r       = e1 + 1 + 4 * FC + 1;
        f_data  = 8'h55;
        f_valid = 1'b1;
        goto(e1);
        f_data  = 8'h11;
        goto(e1 + 1);
        f_data  = 8'h22;
        goto(e1 + 2);
        f_valid = 1'b0;
        goto(r - 1);
        n_vec++; if (f_count !== 3'd2 || f_busy !== 1'b1) begin
            n_err++; $display("FAIL rstmid_pre: count %0d busy %b want 2 1", f_count, f_busy);
        end
        f_rst = 1'b1;
        goto(r);
        f_rst = 1'b0;
        n_vec++; if (f_uart !== 1'b1 || f_busy !== 1'b0 || f_count !== 3'd0 || f_ready !== 1'b1) begin
            n_err++; $display("FAIL rstmid_after: uart %b busy %b count %0d ready %b want 1 0 0 1",
                              f_uart, f_busy, f_count, f_ready);
        end
        bad = 0;
        for (int i = 1; i <= 3 * NB * FC; i++) begin
            goto(r + i);
            if (f_uart !== 1'b1 || f_busy !== 1'b0) bad++;
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL rstmid_quiet: %0d active cycles want 0", bad); end
        mon_clear();
        e       = cyc + 1;
        f_data  = 8'h96;
        f_valid = 1'b1;
        goto(e);
        f_valid = 1'b0;
        goto(e + 1 + NB * FC + 4);
        n_vec++; if (mon_q.size() != 1 || mon_q[0] !== 8'h96 || !mon_ok[0]) begin
            n_err++; $display("FAIL rstmid_next: got %0d bytes first %h want 1 byte 96", mon_q.size(), mon_q[0]);
        end
    endtask

    initial begin
        s_rst = 1'b1; s_valid = 1'b0; s_data = 8'h00;
        f_rst = 1'b1; f_valid = 1'b0; f_data = 8'h00;
        test_reset();
        test_full();
        test_push_pop();
        test_reset_mid();
        test_single();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
